dsp_wdata_channel: RTL and testbench

Per-master write-data dispatcher inside the AXI4 interconnect, directly upstream of the per-slave WDATA arbiters. It takes the W-beat stream of one master, steers each burst to the slave chosen when its AW was accepted, and registers the beat toward that slave's arbiter. It keeps an in-order queue of {slave id, AxLEN} for outstanding write addresses and generates WLAST from AxLEN.

---
 rtl/dsp_wdata_channel_if.sv | 52 +++++
 rtl/dsp_wdata_channel.sv | 141 ++++++++++++++
 tb/tb_dsp_wdata_channel.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_wdata_channel_if.sv
// -----------------------------------------------------------------------------
// dsp_wdata_channel_if
// Bundles every signal of one master's write-data dispatcher: the master W
// beat stream, the order-queue push from the AW channel, the registered beat
// toward the per-slave WDATA arbiters and the sticky error flag.
//
//   slave  modport : the dispatcher's view (master/AW/ready in, beat out)
//   master modport : the environment's view (drives beats, AW pushes, readies)
// -----------------------------------------------------------------------------
interface dsp_wdata_channel_if #(
   parameter int SLV_AMT          = 2,
   parameter int SLV_ID_W         = $clog2(SLV_AMT),
   parameter int DATA_WIDTH       = 32,
   parameter int TRANS_DATA_LEN_W = 3
);
   // master W channel
   logic [DATA_WIDTH-1:0]       m_WDATA_i;
   logic                        m_WLAST_i;
   logic                        m_WVALID_i;
   logic                        m_WREADY_o;
   // order-queue push from the accepted AW
   logic [SLV_ID_W-1:0]         AW_slv_id_i;
   logic [TRANS_DATA_LEN_W-1:0] AW_AxLEN_i;
   logic                        AW_fifo_order_wr_en_i;
   logic                        AW_stall_o;
   // registered beat toward the slave arbiters
   logic [DATA_WIDTH-1:0]       sa_WDATA_o;
   logic                        sa_WLAST_o;
   logic [SLV_AMT-1:0]          sa_WVALID_o;
   logic [SLV_AMT-1:0]          sa_slv_sel_o;
   logic [SLV_AMT-1:0]          sa_WREADY_i;
   // sticky error
   logic                        err_o;

   modport slave (
      input  m_WDATA_i, m_WLAST_i, m_WVALID_i,
      input  AW_slv_id_i, AW_AxLEN_i, AW_fifo_order_wr_en_i,
      input  sa_WREADY_i,
      output m_WREADY_o, AW_stall_o,
      output sa_WDATA_o, sa_WLAST_o, sa_WVALID_o, sa_slv_sel_o,
      output err_o
   );

   modport master (
      output m_WDATA_i, m_WLAST_i, m_WVALID_i,
      output AW_slv_id_i, AW_AxLEN_i, AW_fifo_order_wr_en_i,
      output sa_WREADY_i,
      input  m_WREADY_o, AW_stall_o,
      input  sa_WDATA_o, sa_WLAST_o, sa_WVALID_o, sa_slv_sel_o,
      input  err_o
   );
endinterface

// File: rtl/dsp_wdata_channel.sv
// -----------------------------------------------------------------------------
// dsp_wdata_channel
// Per-master write-data dispatcher. Keeps an in-order queue of
// {slave id, AxLEN} for accepted write addresses, steers each W burst of the
// master to the slave at the queue head, regenerates WLAST from AxLEN and
// registers every beat toward the selected slave's WDATA arbiter.
//
// Ports:
//   ACLK_i   : clock, rising edge
//   ARESET_i : asynchronous active-high reset
//   bus      : dsp_wdata_channel_if.slave
//              m_W*      master beat stream (m_WLAST_i is checked only)
//              AW_*      order-queue push / full stall
//              sa_W*     registered one-hot beat toward the slave arbiters
//              err_o     sticky WLAST-mismatch / bad-slave-id flag
// OUTSTANDING_AMT must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module dsp_wdata_channel #(
   parameter int SLV_AMT          = 2,
   parameter int SLV_ID_W         = $clog2(SLV_AMT),
   parameter int OUTSTANDING_AMT  = 8,
   parameter int DATA_WIDTH       = 32,
   parameter int TRANS_DATA_LEN_W = 3
) (
   input  logic               ACLK_i,
   input  logic               ARESET_i,
   dsp_wdata_channel_if.slave bus
);
   localparam int PTR_W   = $clog2(OUTSTANDING_AMT);
   localparam int ENTRY_W = SLV_ID_W + TRANS_DATA_LEN_W;

   // ---------------------------------------------------------------- order queue
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [ENTRY_W-1:0]          order_mem [OUTSTANDING_AMT];
   logic [PTR_W:0]              wr_ptr_reg;
   logic [PTR_W:0]              rd_ptr_reg;
   logic                        q_empty;
   logic                        q_full;
   logic                        q_push;
   logic                        q_pop;
   logic [SLV_ID_W-1:0]         head_slv;
   logic [TRANS_DATA_LEN_W-1:0] head_len;

   assign q_empty = (wr_ptr_reg == rd_ptr_reg);
   assign q_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                    (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

   // A push while full is lost even if the head pops in the same cycle.
   assign q_push  = bus.AW_fifo_order_wr_en_i & ~q_full;

   // Head is read combinationally so a burst can start the cycle after its
   // AW lands and the next burst can follow its predecessor with no bubble.
   assign {head_slv, head_len} = order_mem[rd_ptr_reg[PTR_W-1:0]];

   always_ff @(posedge ACLK_i) begin
      if (q_push) begin
         order_mem[wr_ptr_reg[PTR_W-1:0]] <= {bus.AW_slv_id_i, bus.AW_AxLEN_i};
      end
   end

   // ------------------------------------------------------------ slave decode
   // An id with no matching port decodes to all-zero; slv_ok flags that case.
   logic [SLV_AMT-1:0] head_onehot;
   logic               slv_ok;

   generate
      for (genvar gi = 0; gi < SLV_AMT; gi++) begin : g_sel
         assign head_onehot[gi] = (32'(head_slv) == gi);
      end
   endgenerate

   assign slv_ok = |head_onehot;

   // ------------------------------------------------------ datapath registers
   logic [TRANS_DATA_LEN_W-1:0] cnt_reg;
   logic                        out_valid_reg;
   logic [DATA_WIDTH-1:0]       out_data_reg;
   logic                        out_last_reg;
   logic [SLV_AMT-1:0]          out_sel_reg;
   logic                        err_reg;

   logic beat_last;
   logic dn_hs;
   logic m_ready;
   logic acc;

   assign beat_last = (cnt_reg == head_len);

   // out_sel_reg is one-hot whenever out_valid_reg is set, so masking the
   // readies with it selects the ready of the addressed arbiter.
   assign dn_hs   = out_valid_reg & |(out_sel_reg & bus.sa_WREADY_i);
   assign m_ready = ~q_empty & (~out_valid_reg | dn_hs);
   assign acc     = bus.m_WVALID_i & m_ready;
   assign q_pop   = acc & beat_last;

   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         cnt_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_last_reg  <= 1'b0;
         out_sel_reg   <= '0;
         err_reg       <= 1'b0;
      end else begin
         if (q_push) begin
            wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
         end
         if (q_pop) begin
            rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
         end

         if (acc) begin
            // A beat for a nonexistent slave is consumed but never presented,
            // otherwise it would wait forever for a ready that cannot come.
            out_valid_reg <= slv_ok;
            out_data_reg  <= bus.m_WDATA_i;
            out_last_reg  <= beat_last;
            out_sel_reg   <= head_onehot;
            cnt_reg       <= beat_last ? '0 : cnt_reg + TRANS_DATA_LEN_W'(1);
            // Routing always follows AxLEN; the master's WLAST is only audited.
            if ((bus.m_WLAST_i != beat_last) || !slv_ok) begin
               err_reg <= 1'b1;
            end
         end else if (dn_hs) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   // ----------------------------------------------------------------- outputs
   assign bus.m_WREADY_o   = m_ready;
   assign bus.AW_stall_o   = q_full;
   assign bus.sa_WDATA_o   = out_data_reg;
   assign bus.sa_WLAST_o   = out_last_reg;
   assign bus.sa_WVALID_o  = out_sel_reg & {SLV_AMT{out_valid_reg}};
   assign bus.sa_slv_sel_o = out_sel_reg & {SLV_AMT{out_valid_reg}};
   assign bus.err_o        = err_reg;

endmodule

// File: tb/tb_dsp_wdata_channel.sv
// -----------------------------------------------------------------------------
// tb_dsp_wdata_channel
// Directed bench for dsp_wdata_channel. Beats are issued from the stimulus
// process, which pushes the hand-derived {select, data, last} into exp_q;
// a monitor pops and compares on every downstream handshake.
// -----------------------------------------------------------------------------
module tb_dsp_wdata_channel;
   localparam int SLV_AMT          = 2;
   localparam int SLV_ID_W         = 1;
   localparam int OUTSTANDING_AMT  = 8;
   localparam int DATA_WIDTH       = 32;
   localparam int TRANS_DATA_LEN_W = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dsp_wdata_channel_if #(
      .SLV_AMT(SLV_AMT), .SLV_ID_W(SLV_ID_W),
      .DATA_WIDTH(DATA_WIDTH), .TRANS_DATA_LEN_W(TRANS_DATA_LEN_W)
   ) bus ();

   dsp_wdata_channel #(
      .SLV_AMT(SLV_AMT), .SLV_ID_W(SLV_ID_W), .OUTSTANDING_AMT(OUTSTANDING_AMT),
      .DATA_WIDTH(DATA_WIDTH), .TRANS_DATA_LEN_W(TRANS_DATA_LEN_W)
   ) dut (
      .ACLK_i  (clk),
      .ARESET_i(rst),
      .bus     (bus)
   );

   typedef struct packed {
      logic [1:0]  sel;
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && (|(bus.sa_WVALID_o & bus.sa_WREADY_i))) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_beat: got data 0x%0h sel %b, expected no beat",
                        bus.sa_WDATA_o, bus.sa_slv_sel_o);
            end else begin
               e = exp_q.pop_front();
               chk("beat_sel",  32'(bus.sa_slv_sel_o), 32'(e.sel));
               chk("beat_data", bus.sa_WDATA_o, e.data);
               chk("beat_last", 32'(bus.sa_WLAST_o), 32'(e.last));
               $display("beat  sel=%b data=0x%08h last=%0b", bus.sa_slv_sel_o,
                        bus.sa_WDATA_o, bus.sa_WLAST_o);
            end
         end
      end
   end

   // --------------------------------------------------------------- watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ----------------------------------------------------------------- tasks
   // Starts at posedge+1, returns at posedge+1 of the cycle after the push.
   task automatic push_aw(input int slv, input int len, input bit chk_ready);
      bus.AW_slv_id_i           = SLV_ID_W'(slv);
      bus.AW_AxLEN_i            = TRANS_DATA_LEN_W'(len);
      bus.AW_fifo_order_wr_en_i = 1'b1;
      @(negedge clk);
      if (chk_ready) chk("push_cycle_wready", 32'(bus.m_WREADY_o), 32'(0));
      @(posedge clk);
      #1;
      bus.AW_fifo_order_wr_en_i = 1'b0;
      $display("aw    slv=%0d len=%0d stall=%0b", slv, len, bus.AW_stall_o);
   endtask

   // Presents one beat, waits (bounded) for acceptance, then checks the
   // registered output one cycle later. WVALID is left asserted.
   task automatic send_beat(input logic [31:0] data, input logic wlast,
                            input int slv, input logic exp_last, output int waited);
      exp_t e;
      logic [1:0] oh;
      oh = 2'(1 << slv);
      bus.m_WDATA_i  = data;
      bus.m_WLAST_i  = wlast;
      bus.m_WVALID_i = 1'b1;
      e.sel  = oh;
      e.data = data;
      e.last = exp_last;
      exp_q.push_back(e);
      waited = 0;
      forever begin
         @(negedge clk);
         if (bus.m_WREADY_o) break;
         waited++;
         if (waited >= 50) break;
      end
      if (waited >= 50) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: data 0x%0h not accepted after %0d cycles, required acceptance",
                  data, waited);
      end
      @(posedge clk);
      #1;
      chk("lat_valid", 32'(bus.sa_WVALID_o), 32'(oh));
      chk("lat_data",  bus.sa_WDATA_o, data);
      chk("lat_last",  32'(bus.sa_WLAST_o), 32'(exp_last));
      $display("issue data=0x%08h wlast=%0b slv=%0d waited=%0d", data, wlast, slv, waited);
   endtask

   task automatic idle();
      bus.m_WVALID_i = 1'b0;
      bus.m_WLAST_i  = 1'b0;
   endtask

   // --------------------------------------------------------------- stimulus
   initial begin : stim
      int w;
      bus.m_WDATA_i             = '0;
      bus.m_WLAST_i             = 1'b0;
      bus.m_WVALID_i            = 1'b0;
      bus.AW_slv_id_i           = '0;
      bus.AW_AxLEN_i            = '0;
      bus.AW_fifo_order_wr_en_i = 1'b0;
      bus.sa_WREADY_i           = 2'b11;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wready", 32'(bus.m_WREADY_o),   32'(0));
      chk("rst_stall",  32'(bus.AW_stall_o),   32'(0));
      chk("rst_valid",  32'(bus.sa_WVALID_o),  32'(0));
      chk("rst_sel",    32'(bus.sa_slv_sel_o), 32'(0));
      chk("rst_data",   bus.sa_WDATA_o,        32'(0));
      chk("rst_last",   32'(bus.sa_WLAST_o),   32'(0));
      chk("rst_err",    32'(bus.err_o),        32'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;

      // single burst {slv 1, len 3}
      push_aw(1, 3, 1'b1);
      send_beat(32'hD000_0000, 1'b0, 1, 1'b0, w);
      send_beat(32'hD000_0001, 1'b0, 1, 1'b0, w);
      chk("single_nogap1", 32'(w), 32'(0));
      send_beat(32'hD000_0002, 1'b0, 1, 1'b0, w);
      send_beat(32'hD000_0003, 1'b1, 1, 1'b1, w);
      chk("single_nogap3", 32'(w), 32'(0));
      idle();
      @(negedge clk);
      chk("single_q_empty", 32'(bus.m_WREADY_o), 32'(0));
      chk("single_err",     32'(bus.err_o),      32'(0));
      @(posedge clk);
      #1;

      // back-to-back bursts {0,0} then {1,1}
      push_aw(0, 0, 1'b1);
      push_aw(1, 1, 1'b0);
      send_beat(32'hB000_0000, 1'b1, 0, 1'b1, w);
      send_beat(32'hB000_0001, 1'b0, 1, 1'b0, w);
      chk("b2b_nogap1", 32'(w), 32'(0));
      send_beat(32'hB000_0002, 1'b1, 1, 1'b1, w);
      chk("b2b_nogap2", 32'(w), 32'(0));
      idle();
      @(posedge clk);
      #1;

      // backpressure on slave 0 for 3 cycles mid-burst
      push_aw(0, 3, 1'b0);
      send_beat(32'hA000_0000, 1'b0, 0, 1'b0, w);
      send_beat(32'hA000_0001, 1'b0, 0, 1'b0, w);
      bus.sa_WREADY_i = 2'b10;
      bus.m_WDATA_i   = 32'hA000_0002;
      bus.m_WLAST_i   = 1'b0;
      bus.m_WVALID_i  = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_wready", 32'(bus.m_WREADY_o), 32'(0));
         chk("bp_hold_data", bus.sa_WDATA_o, 32'hA000_0001);
         chk("bp_hold_last", 32'(bus.sa_WLAST_o), 32'(0));
      end
      @(posedge clk);
      #1;
      bus.sa_WREADY_i = 2'b11;
      send_beat(32'hA000_0002, 1'b0, 0, 1'b0, w);
      send_beat(32'hA000_0003, 1'b1, 0, 1'b1, w);
      idle();
      @(posedge clk);
      #1;

      // queue full: 8 pushes, a 9th one dropped
      for (int i = 0; i < OUTSTANDING_AMT; i++) push_aw(1, 0, 1'b0);
      @(negedge clk);
      chk("full_stall", 32'(bus.AW_stall_o), 32'(1));
      @(posedge clk);
      #1;
      push_aw(0, 0, 1'b0);
      @(negedge clk);
      chk("full_stall_9th", 32'(bus.AW_stall_o), 32'(1));
      @(posedge clk);
      #1;
      send_beat(32'hF000_0000, 1'b1, 1, 1'b1, w);
      chk("full_stall_clear", 32'(bus.AW_stall_o), 32'(0));
      for (int i = 1; i < OUTSTANDING_AMT; i++) begin
         send_beat(32'hF000_0000 + i, 1'b1, 1, 1'b1, w);
      end
      idle();
      @(negedge clk);
      chk("full_9th_dropped", 32'(bus.m_WREADY_o), 32'(0));
      chk("full_err", 32'(bus.err_o), 32'(0));
      @(posedge clk);
      #1;

      // WLAST mismatch: {0,1}, master WLAST on first beat
      push_aw(0, 1, 1'b0);
      send_beat(32'hC000_0000, 1'b1, 0, 1'b0, w);
      chk("mismatch_err", 32'(bus.err_o), 32'(1));
      send_beat(32'hC000_0001, 1'b1, 0, 1'b1, w);
      chk("mismatch_err_sticky", 32'(bus.err_o), 32'(1));
      idle();
      @(posedge clk);
      #1;

      // reset during beat 2 of a len=3 burst
      push_aw(1, 3, 1'b0);
      send_beat(32'hE000_0000, 1'b0, 1, 1'b0, w);
      send_beat(32'hE000_0001, 1'b0, 1, 1'b0, w);
      bus.m_WDATA_i  = 32'hE000_0002;
      bus.m_WLAST_i  = 1'b0;
      bus.m_WVALID_i = 1'b1;
      #1;
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("mrst_wready", 32'(bus.m_WREADY_o),   32'(0));
      chk("mrst_stall",  32'(bus.AW_stall_o),   32'(0));
      chk("mrst_valid",  32'(bus.sa_WVALID_o),  32'(0));
      chk("mrst_sel",    32'(bus.sa_slv_sel_o), 32'(0));
      chk("mrst_data",   bus.sa_WDATA_o,        32'(0));
      chk("mrst_last",   32'(bus.sa_WLAST_o),   32'(0));
      chk("mrst_err",    32'(bus.err_o),        32'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_wready", 32'(bus.m_WREADY_o), 32'(0));
      end
      @(posedge clk);
      #1;
      push_aw(0, 0, 1'b1);
      send_beat(32'h5000_0000, 1'b1, 0, 1'b1, w);
      idle();
      chk("post_rst_err", 32'(bus.err_o), 32'(0));

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
